servo_slew_controller: RTL

//  Parametrised N-channel servo driver; next generation of the fixed 3-servo arm path.

---
 rtl/servo_slew_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/servo_slew_controller.sv
// servo_slew_controller
//   N-channel servo driver. Each channel's position is slew-limited toward a
//   target once per PWM frame. The target comes from memory (unsigned) or from
//   the accelerometer (signed, converted to offset binary). Because every move
//   is slew-limited, switching the target source never makes the arm jump.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active-high
//   select_source  1 = accelerometer targets, 0 = memory targets
//   hold           1 = freeze all positions; PWM keeps running
//   target_mem     unsigned targets, channel i at [i*W +: W]
//   target_accel   signed two's-complement targets, same packing
//   pos_out        current slewed positions, same packing
//   pwm_out        one PWM output per channel
//   at_target      1 = channel position equals its selected target
//   frame_start    one-cycle pulse in the cycle where the frame counter is 0
module servo_slew_controller #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 10,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int PWM_FREQ   = 50,
    parameter int MIN_DC     = 25_000,
    parameter int MAX_DC     = 125_000,
    parameter int SLEW_STEP  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         select_source,
    input  logic                         hold,
    input  logic [NUM_CH*DATA_WIDTH-1:0] target_mem,
    input  logic [NUM_CH*DATA_WIDTH-1:0] target_accel,
    output logic [NUM_CH*DATA_WIDTH-1:0] pos_out,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic [NUM_CH-1:0]            at_target,
    output logic                         frame_start
);

    localparam int W      = DATA_WIDTH;
    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW     = $clog2(MAX_DC + 1);
    localparam int PW     = W + $clog2(MAX_DC);
    localparam int XW     = (CW > DW) ? CW : DW;
    localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

    // Full-width product, shifted only after the multiply so no precision is lost.
    function automatic logic [DW-1:0] duty_of(input logic [W-1:0] p);
        logic [PW-1:0] prod;
        prod    = PW'(p) * PW'(MAX_DC - MIN_DC);
        duty_of = DW'(MIN_DC) + DW'(prod >> W);
    endfunction

    // One slew step toward t; the step never overshoots, so no wrap is possible.
    function automatic logic [W-1:0] slew_of(input logic [W-1:0] p, input logic [W-1:0] t);
        int d;
        d = int'(t) - int'(p);
        if (d > SLEW_STEP) begin
            slew_of = p + W'(SLEW_STEP);
        end else if (d < -SLEW_STEP) begin
            slew_of = p - W'(SLEW_STEP);
        end else begin
            slew_of = t;
        end
    endfunction

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          frame_edge_s;
    logic [W-1:0]  pos_r       [NUM_CH];
    logic [W-1:0]  pos_next_s  [NUM_CH];
    logic [W-1:0]  tgt_s       [NUM_CH];
    logic [DW-1:0] duty_r      [NUM_CH];
    logic [DW-1:0] duty_next_s [NUM_CH];
    logic [NUM_CH-1:0] pwm_r;
    logic [NUM_CH-1:0] at_target_r;
    logic          frame_start_r;

    // Frame counter next value; the frame edge is the edge leaving PERIOD-1.
    always_comb begin
        frame_edge_s = (cnt_r == CW'(PERIOD - 1));
        if (frame_edge_s) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
    end

    // Per-channel target select, slew and duty next-state.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_s[i]       = '0;
            pos_next_s[i]  = pos_r[i];
            duty_next_s[i] = duty_r[i];
            // Flipping the sign bit turns two's complement into offset binary.
            if (select_source) begin
                tgt_s[i] = target_accel[i*W +: W] ^ MID;
            end else begin
                tgt_s[i] = target_mem[i*W +: W];
            end
            if (frame_edge_s && !hold) begin
                pos_next_s[i] = slew_of(pos_r[i], tgt_s[i]);
            end else begin
                pos_next_s[i] = pos_r[i];
            end
            if (frame_edge_s) begin
                duty_next_s[i] = duty_of(pos_next_s[i]);
            end else begin
                duty_next_s[i] = duty_r[i];
            end
        end
    end

    // Counter, frame pulse and per-channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= '0;
            frame_start_r <= 1'b0;
            pwm_r         <= '0;
            at_target_r   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pos_r[i]  <= MID;
                duty_r[i] <= duty_of(MID);
            end
        end else begin
            cnt_r         <= cnt_next_s;
            frame_start_r <= frame_edge_s;
            for (int i = 0; i < NUM_CH; i++) begin
                pos_r[i]       <= pos_next_s[i];
                duty_r[i]      <= duty_next_s[i];
                // Compare against the duty that is live in the upcoming cycle, so
                // a new duty takes effect exactly at cnt == 0.
                pwm_r[i]       <= (XW'(cnt_next_s) < XW'(duty_next_s[i]));
                at_target_r[i] <= (pos_next_s[i] == tgt_s[i]);
            end
        end
    end

    // Output packing straight from registers.
    always_comb begin
        pos_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pos_out[i*W +: W] = pos_r[i];
        end
    end

    assign pwm_out     = pwm_r;
    assign at_target   = at_target_r;
    assign frame_start = frame_start_r;

endmodule
